// File: rtl/mem_read_responder.sv
// Main-memory responder for cache line fills: one read or write per cycle, read data returned
// exactly LATENCY cycles after issue through a valid/data shift pipeline.
module mem_read_responder #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int LATENCY = 4,
    parameter int MEM_AW  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic [3:0]        pending
);

    logic [DATA_W-1:0] mem [2**MEM_AW];

    logic [ADDR_W-2:0] word_idx;
    logic [MEM_AW-1:0] mem_idx;
    logic              issue;
    logic              unused_addr;

    // Byte address to word index; index bits above MEM_AW alias onto the stored array.
    assign word_idx    = addr[ADDR_W-1:1];
    assign mem_idx     = MEM_AW'(word_idx);
    assign unused_addr = ^addr;
    assign issue       = enable & ~wr;

    logic              stage_valid [LATENCY];
    logic [DATA_W-1:0] stage_data  [LATENCY];
    logic              in_valid    [LATENCY];
    logic [DATA_W-1:0] in_data     [LATENCY];

    always_ff @(posedge clk) begin
        if (enable && wr) begin
            mem[mem_idx] <= data_in;
        end
    end

    // Stage 0 captures the array word at issue, so later writes cannot disturb an in-flight read.
    always_comb begin
        in_valid[0] = issue;
        in_data[0]  = mem[mem_idx];
        for (int k = 1; k < LATENCY; k++) begin
            in_valid[k] = stage_valid[k-1];
            in_data[k]  = stage_data[k-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < LATENCY; k++) begin
            if (rst) begin
                stage_valid[k] <= 1'b0;
            end else begin
                stage_valid[k] <= in_valid[k];
            end
        end
    end

    // The last data stage only loads on a real beat, which makes data_out hold its last delivered value.
    always_ff @(posedge clk) begin
        for (int k = 0; k < LATENCY; k++) begin
            if (k == LATENCY - 1) begin
                if (rst) begin
                    stage_data[k] <= '0;
                end else if (in_valid[k]) begin
                    stage_data[k] <= in_data[k];
                end
            end else begin
                stage_data[k] <= in_data[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 4'd0;
        end else begin
            case ({issue, data_valid})
                2'b10:   pending <= pending + 4'd1;
                2'b01:   pending <= pending - 4'd1;
                default: pending <= pending;
            endcase
        end
    end

    assign data_valid = stage_valid[LATENCY-1];
    assign data_out   = stage_data[LATENCY-1];

endmodule

// File: tb/tb_mem_read_responder.sv
// Bench for mem_read_responder: directed fill-protocol scenarios followed by random traffic,
// all checked cycle by cycle against a queue-of-scheduled-beats reference model.
module tb_mem_read_responder;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int LATENCY = 4;
    localparam int MEM_AW  = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic [3:0]        pending;

    mem_read_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(LATENCY), .MEM_AW(MEM_AW)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr), .data_in(data_in),
        .data_out(data_out), .data_valid(data_valid), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              due;
        logic [DATA_W-1:0] data;
    } beat_t;

    beat_t             expQ[$];
    logic [DATA_W-1:0] modelMem [int];
    logic [DATA_W-1:0] lastOut;
    int                cyc = 0;
    int                vectors = 0;
    int                miscompares = 0;
    int                peakPending;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    function automatic int wordIdx(input logic [ADDR_W-1:0] a);
        return int'((32'(a) >> 1) & ((32'd1 << MEM_AW) - 1));
    endfunction

    // One request cycle: drive inputs, update the model at the edge, then check the new cycle.
    task automatic applyStimulus(input logic r, input logic en, input logic w,
                                 input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        beat_t b;
        logic  expValid;
        rst = r; enable = en; wr = w; addr = a; data_in = d;
        @(posedge clk);
        #1;
        if (r) begin
            expQ.delete();
            lastOut = '0;
        end else if (en && w) begin
            modelMem[wordIdx(a)] = d;
        end else if (en) begin
            b.due  = cyc + 1 + LATENCY - 1 + 0;
            b.due  = cyc + LATENCY;
            b.data = modelMem.exists(wordIdx(a)) ? modelMem[wordIdx(a)] : 'x;
            expQ.push_back(b);
        end
        cyc++;
        checkOutput("pending", 32'(pending), 32'(expQ.size()));
        if (int'(pending) > peakPending) peakPending = int'(pending);
        expValid = (expQ.size() > 0) && (expQ[0].due == cyc);
        checkOutput("data_valid", 32'(data_valid), 32'(expValid));
        if (expValid) begin
            lastOut = expQ[0].data;
            void'(expQ.pop_front());
        end
        checkOutput("data_out", 32'(data_out), 32'(lastOut));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic writeWord(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        applyStimulus(1'b0, 1'b1, 1'b1, a, d);
    endtask

    task automatic readWord(input logic [ADDR_W-1:0] a);
        applyStimulus(1'b0, 1'b1, 1'b0, a, '0);
    endtask

    initial begin
        int op;
        logic [ADDR_W-1:0] ra;
        rst = 1'b1; enable = 1'b0; wr = 1'b0; addr = '0; data_in = '0;

        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
        idle(2);

        // single read of a freshly written word
        writeWord(16'h0040, 16'hBEEF);
        idle(2);
        readWord(16'h0040);
        idle(6);

        // back-to-back line fill
        for (int i = 0; i < 8; i++) writeWord(16'h1100 + 16'(2 * i), 16'h00A0 + 16'(i));
        idle(1);
        peakPending = 0;
        for (int i = 0; i < 8; i++) readWord(16'h1100 + 16'(2 * i));
        idle(6);
        checkOutput("peak_pending", 32'(peakPending), 32'(LATENCY));

        // capture at issue
        writeWord(16'h0200, 16'h1111);
        idle(1);
        readWord(16'h0200);
        writeWord(16'h0200, 16'h2222);
        readWord(16'h0200);
        idle(6);

        // gapped requests
        readWord(16'h1100);
        idle(1);
        readWord(16'h1102);
        readWord(16'h1104);
        idle(6);

        // reset mid-burst, then confirm the array survived
        readWord(16'h1100);
        readWord(16'h1102);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
        idle(6);
        readWord(16'h1106);
        idle(5);

        // odd byte address returns the containing word
        readWord(16'h0041);
        idle(5);

        // random traffic over a small preloaded window
        for (int i = 0; i < 16; i++) writeWord(16'h3000 + 16'(2 * i), 16'($urandom));
        for (int i = 0; i < 600; i++) begin
            op = int'($urandom_range(0, 99));
            ra = 16'h3000 + 16'(2 * $urandom_range(0, 15)) + 16'($urandom_range(0, 1));
            if (op < 10) writeWord(ra, 16'($urandom));
            else if (op < 65) readWord(ra);
            else if (op < 96) idle(1);
            else applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
        end
        idle(LATENCY + 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
